// File: rtl/disp_scan_ctrl_if.sv
// Display scan bus: tick clock, enable, digit double-buffer load handshake and
// the multiplexed anode/segment drive back from the controller.
interface disp_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    ScanClk;
  logic                    Enable;
  logic [4*NUM_DIGITS-1:0] DigitsIn;
  logic [NUM_DIGITS-1:0]   BlankMaskIn;
  logic                    Load;
  logic                    LoadAck;
  logic [NUM_DIGITS-1:0]   Anode;
  logic [6:0]              Seg;
  logic                    FrameDone;

  modport master (
    output ScanClk,
    output Enable,
    output DigitsIn,
    output BlankMaskIn,
    output Load,
    input  LoadAck,
    input  Anode,
    input  Seg,
    input  FrameDone
  );

  modport slave (
    input  ScanClk,
    input  Enable,
    input  DigitsIn,
    input  BlankMaskIn,
    input  Load,
    output LoadAck,
    output Anode,
    output Seg,
    output FrameDone
  );
endinterface

// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display with
// per-digit ghost blanking and frame-aligned double-buffered digit updates.
//
// state   | meaning
// stOff   | display dark, scan position held at digit 0
// stBlank | all anodes off ahead of digit idx
// stDrive | digit idx driven with its segment pattern
module disp_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int BLANK_TICKS = 1,
  parameter int DRIVE_TICKS = 3
) (
  input logic             Clk,
  input logic             Rst,
  disp_scan_ctrl_if.slave bus
);
  localparam int IDX_W     = $clog2(NUM_DIGITS);
  localparam int MAX_TICKS = (BLANK_TICKS > DRIVE_TICKS) ? BLANK_TICKS : DRIVE_TICKS;
  localparam int CNT_W     = $clog2(MAX_TICKS + 1);

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_TICKS - 1);
  localparam logic [CNT_W-1:0] DRIVE_LOAD = CNT_W'(DRIVE_TICKS - 1);

  typedef enum logic [1:0] {
    stOff   = 2'd0,
    stBlank = 2'd1,
    stDrive = 2'd2
  } scanState_t;

  scanState_t              state, stateNext;
  logic [IDX_W-1:0]        idx, idxNext;
  logic [CNT_W-1:0]        tickCnt, cntNext;
  logic                    scanClkD;
  logic                    tick;
  logic                    frameEnd;
  logic                    xfer;

  logic [4*NUM_DIGITS-1:0] shadowDigits, activeDigits;
  logic [NUM_DIGITS-1:0]   shadowMask, activeMask;
  logic                    pending;

  logic [3:0]              digitSel;
  logic                    maskSel;
  logic                    driveOn;
  logic [NUM_DIGITS-1:0]   anodeNext, anodeQ;
  logic [6:0]              segNext, segQ;
  logic                    loadAckQ, frameDoneQ;

  function automatic logic [6:0] hex7seg(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0: pat = 7'h40;
      4'h1: pat = 7'h79;
      4'h2: pat = 7'h24;
      4'h3: pat = 7'h30;
      4'h4: pat = 7'h19;
      4'h5: pat = 7'h12;
      4'h6: pat = 7'h02;
      4'h7: pat = 7'h78;
      4'h8: pat = 7'h00;
      4'h9: pat = 7'h10;
      4'hA: pat = 7'h08;
      4'hB: pat = 7'h03;
      4'hC: pat = 7'h46;
      4'hD: pat = 7'h21;
      4'hE: pat = 7'h06;
      4'hF: pat = 7'h0E;
      default: pat = 7'h7F;
    endcase
    return pat;
  endfunction

  assign tick = bus.ScanClk & ~scanClkD;

  // Tick counter runs down from the per-state length; zero on a tick ends the state.
  always_comb begin
    stateNext = state;
    idxNext   = idx;
    cntNext   = tickCnt;
    frameEnd  = 1'b0;
    if (!bus.Enable) begin
      stateNext = stOff;
      idxNext   = '0;
      cntNext   = '0;
    end else begin
      case (state)
        stOff: begin
          stateNext = stBlank;
          idxNext   = '0;
          cntNext   = BLANK_LOAD;
        end
        stBlank: begin
          if (tick) begin
            if (tickCnt == '0) begin
              stateNext = stDrive;
              cntNext   = DRIVE_LOAD;
            end else begin
              cntNext = tickCnt - 1'b1;
            end
          end
        end
        stDrive: begin
          if (tick) begin
            if (tickCnt == '0) begin
              stateNext = stBlank;
              cntNext   = BLANK_LOAD;
              if (idx == LAST_IDX) begin
                idxNext  = '0;
                frameEnd = 1'b1;
              end else begin
                idxNext = idx + 1'b1;
              end
            end else begin
              cntNext = tickCnt - 1'b1;
            end
          end
        end
        default: begin
          stateNext = stOff;
          idxNext   = '0;
          cntNext   = '0;
        end
      endcase
    end
  end

  assign xfer = pending & (frameEnd | (state == stOff));

  // Active regs only change at a frame end or while dark, so decoding them
  // against the next scan position gives a stable pattern through DRIVE.
  always_comb begin
    digitSel = 4'h0;
    maskSel  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idxNext == IDX_W'(i)) begin
        digitSel = activeDigits[4*i +: 4];
        maskSel  = activeMask[i];
      end
    end
    driveOn   = (stateNext == stDrive) & ~maskSel;
    anodeNext = '1;
    segNext   = 7'h7F;
    if (driveOn) begin
      segNext = hex7seg(digitSel);
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (idxNext == IDX_W'(i)) begin
          anodeNext[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state        <= stOff;
      idx          <= '0;
      tickCnt      <= '0;
      scanClkD     <= 1'b0;
      shadowDigits <= '0;
      shadowMask   <= '0;
      pending      <= 1'b0;
      activeDigits <= '0;
      activeMask   <= '0;
      anodeQ       <= '1;
      segQ         <= 7'h7F;
      loadAckQ     <= 1'b0;
      frameDoneQ   <= 1'b0;
    end else begin
      state      <= stateNext;
      idx        <= idxNext;
      tickCnt    <= cntNext;
      scanClkD   <= bus.ScanClk;
      anodeQ     <= anodeNext;
      segQ       <= segNext;
      loadAckQ   <= bus.Load;
      frameDoneQ <= frameEnd;
      if (xfer) begin
        activeDigits <= shadowDigits;
        activeMask   <= shadowMask;
      end
      // A capture in the same cycle as a transfer stays pending for the next frame.
      if (bus.Load) begin
        shadowDigits <= bus.DigitsIn;
        shadowMask   <= bus.BlankMaskIn;
        pending      <= 1'b1;
      end else if (xfer) begin
        pending <= 1'b0;
      end
    end
  end

  assign bus.Anode     = anodeQ;
  assign bus.Seg       = segQ;
  assign bus.LoadAck   = loadAckQ;
  assign bus.FrameDone = frameDoneQ;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Randomized bench for disp_scan_ctrl against a frame-position reference model.
module tb_disp_scan_ctrl;
  localparam int NUM_DIGITS  = 4;
  localparam int BLANK_TICKS = 1;
  localparam int DRIVE_TICKS = 3;
  localparam int SLOT        = BLANK_TICKS + DRIVE_TICKS;
  localparam int FRAME       = NUM_DIGITS * SLOT;

  logic Clk = 1'b0;
  logic Rst;
  int   checks   = 0;
  int   failures = 0;

  disp_scan_ctrl_if #(.NUM_DIGITS(NUM_DIGITS)) bus();

  disp_scan_ctrl #(
    .NUM_DIGITS (NUM_DIGITS),
    .BLANK_TICKS(BLANK_TICKS),
    .DRIVE_TICKS(DRIVE_TICKS)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .bus(bus)
  );

  always #5 Clk = ~Clk;

  // Reference model: scan position counted in ticks from the start of a frame.
  logic [6:0]              hexTbl [16];
  bit                      mScanning;
  int                      mPos;
  bit                      mPrevScan;
  logic [4*NUM_DIGITS-1:0] mActive, mShadow;
  logic [NUM_DIGITS-1:0]   mActiveMask, mShadowMask;
  bit                      mPending;
  logic [NUM_DIGITS-1:0]   expAnode;
  logic [6:0]              expSeg;
  bit                      expAck, expDone;
  int                      scanHalf, scanPhase;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic doXfer();
    mActive     = mShadow;
    mActiveMask = mShadowMask;
    mPending    = 1'b0;
  endtask

  task automatic modelEdge();
    bit tickM;
    bit frameEnd;
    int digit;
    tickM     = bus.ScanClk && !mPrevScan;
    mPrevScan = bus.ScanClk;
    frameEnd  = 1'b0;
    if (Rst) begin
      mScanning = 0; mPos = 0; mPrevScan = 0;
      mActive = '0; mActiveMask = '0; mShadow = '0; mShadowMask = '0; mPending = 0;
      expAck = 0;
    end else begin
      if (!bus.Enable) begin
        if (!mScanning && mPending) doXfer();
        mScanning = 0;
        mPos      = 0;
      end else if (!mScanning) begin
        if (mPending) doXfer();
        mScanning = 1;
        mPos      = 0;
      end else if (tickM) begin
        mPos++;
        if (mPos == FRAME) begin
          mPos     = 0;
          frameEnd = 1'b1;
          if (mPending) doXfer();
        end
      end
      if (bus.Load) begin
        mShadow     = bus.DigitsIn;
        mShadowMask = bus.BlankMaskIn;
        mPending    = 1'b1;
      end
      expAck = bus.Load;
    end
    expDone  = frameEnd;
    expAnode = '1;
    expSeg   = 7'h7F;
    if (mScanning) begin
      digit = mPos / SLOT;
      if ((mPos % SLOT) >= BLANK_TICKS && !mActiveMask[digit]) begin
        expAnode[digit] = 1'b0;
        expSeg          = hexTbl[mActive[4*digit +: 4]];
      end
    end
  endtask

  task automatic stepCycle();
    @(posedge Clk);
    modelEdge();
    @(negedge Clk);
    checkVal("anode", 32'(bus.Anode), 32'(expAnode));
    checkVal("seg", 32'(bus.Seg), 32'(expSeg));
    checkVal("loadAck", 32'(bus.LoadAck), 32'(expAck));
    checkVal("frameDone", 32'(bus.FrameDone), 32'(expDone));
    scanPhase++;
    if (scanPhase >= scanHalf) begin
      scanPhase   = 0;
      bus.ScanClk = ~bus.ScanClk;
    end
  endtask

  task automatic loadDigits(input logic [15:0] digits, input logic [3:0] mask);
    bus.DigitsIn    = digits;
    bus.BlankMaskIn = mask;
    bus.Load        = 1'b1;
    stepCycle();
    bus.Load = 1'b0;
  endtask

  function automatic bit inDriveOf(input int digit);
    return mScanning && (mPos / SLOT == digit) && (mPos % SLOT >= BLANK_TICKS);
  endfunction

  initial begin
    hexTbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    mScanning = 0; mPos = 0; mPrevScan = 0; mPending = 0;
    mActive = '0; mShadow = '0; mActiveMask = '0; mShadowMask = '0;
    Rst = 1'b1;
    bus.ScanClk = 1'b0; bus.Enable = 1'b0; bus.Load = 1'b0;
    bus.DigitsIn = '0; bus.BlankMaskIn = '0;
    scanHalf = 4; scanPhase = 0;

    // Reset held, then idle with the display disabled.
    repeat (3) stepCycle();
    Rst = 1'b0;
    repeat (5) stepCycle();

    // Load 1234 and scan three frames with ScanClk period 8.
    loadDigits(16'h1234, 4'b0000);
    bus.Enable = 1'b1;
    repeat (3 * FRAME * 8) stepCycle();

    // Mid-frame update lands on the next frame boundary.
    repeat (50) stepCycle();
    loadDigits(16'hABCD, 4'b0000);
    repeat (2 * FRAME * 8) stepCycle();

    // Suppress digit 2.
    loadDigits(16'hABCD, 4'b0100);
    repeat (2 * FRAME * 8) stepCycle();
    loadDigits(16'h5E6F, 4'b0000);
    repeat (FRAME * 8 + 20) stepCycle();

    // Drop Enable while digit 2 is driven, then re-enable.
    for (int n = 0; n < 2 * FRAME * 8 && !inDriveOf(2); n++) stepCycle();
    checkVal("reachDrive2", 32'(inDriveOf(2)), 32'd1);
    bus.Enable = 1'b0;
    repeat (3) stepCycle();
    bus.Enable = 1'b1;
    repeat (FRAME * 8) stepCycle();

    // Reset during DRIVE with a load still pending.
    for (int n = 0; n < 2 * FRAME * 8 && !inDriveOf(1); n++) stepCycle();
    loadDigits(16'h9876, 4'b0000);
    checkVal("pendingBeforeRst", 32'(mPending), 32'd1);
    Rst = 1'b1;
    repeat (2) stepCycle();
    Rst = 1'b0;
    repeat (FRAME * 8 + 10) stepCycle();

    // Fast ScanClk with frequent loads to hit loads on frame boundaries.
    scanHalf = 1;
    for (int c = 0; c < 800; c++) begin
      bus.Load = ($urandom_range(0, 2) == 0);
      if (bus.Load) begin
        bus.DigitsIn    = 16'($urandom);
        bus.BlankMaskIn = 4'($urandom);
      end
      stepCycle();
    end

    // Fully random traffic.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 199) == 0) scanHalf = $urandom_range(1, 5);
      Rst        = ($urandom_range(0, 999) == 0);
      bus.Enable = ($urandom_range(0, 249) != 0);
      bus.Load   = ($urandom_range(0, 29) == 0);
      if (bus.Load) begin
        bus.DigitsIn    = 16'($urandom);
        bus.BlankMaskIn = 4'($urandom);
      end
      stepCycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
